// File: rtl/elevator_scheduler.sv
// elevator_scheduler: single-car SCAN scheduler that latches floor requests, picks travel
// direction, times floor-to-floor travel and door dwell, and pulses the serviced button clear.
//   CLK                in   system clock, rising edge
//   RESET              in   asynchronous active-low reset
//   FLOOR_REQUEST      in   button inputs, bit i = floor i
//   CURRENT_FLOOR      out  registered car position
//   HALTED             out  1 unless the car is moving
//   DOOR_OPEN          out  1 while the door dwells
//   MOVING_UP/DOWN     out  travel direction while moving
//   PENDING            out  registered pending-request set
//   CLEAR_FLOOR_BUTTON out  one-cycle one-hot pulse for the floor just serviced
module elevator_scheduler #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_BITS    = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int TIMER_BITS    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [FLOORS-1:0]     FLOOR_REQUEST,
    output logic [FLOOR_BITS-1:0] CURRENT_FLOOR,
    output logic                  HALTED,
    output logic                  DOOR_OPEN,
    output logic                  MOVING_UP,
    output logic                  MOVING_DOWN,
    output logic [FLOORS-1:0]     PENDING,
    output logic [FLOORS-1:0]     CLEAR_FLOOR_BUTTON
);
    typedef enum logic [1:0] {IDLE, MOVE, DOOR, CHECK} state_t;

    state_t                state_q, state_d;
    logic [FLOOR_BITS-1:0] floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [FLOORS-1:0]     pending_q, pending_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [FLOORS-1:0]     clear_q;
    logic [FLOORS-1:0]     svc, floor_oh;
    logic                  above, below, here;

    always_comb begin
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            above |= pending_q[i] && (FLOOR_BITS'(i) > floor_q);
            below |= pending_q[i] && (FLOOR_BITS'(i) < floor_q);
        end
        here     = pending_q[floor_q];
        floor_oh = FLOORS'(1) << floor_q;
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        svc      = '0;
        case (state_q)
            IDLE, CHECK: begin
                if (here) begin
                    state_d = DOOR;
                    svc     = floor_oh;
                    timer_d = TIMER_BITS'(DOOR_CYCLES - 1);
                end else if (dir_q ? above : below) begin
                    state_d = MOVE;
                    timer_d = TIMER_BITS'(TRAVEL_CYCLES - 1);
                end else if (dir_q ? below : above) begin
                    state_d = MOVE;
                    dir_d   = ~dir_q;
                    timer_d = TIMER_BITS'(TRAVEL_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (timer_q == '0) begin
                    floor_d = dir_q ? floor_q + FLOOR_BITS'(1) : floor_q - FLOOR_BITS'(1);
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q - TIMER_BITS'(1);
                end
            end
            DOOR: begin
                // A press for the open floor is absorbed without restarting the dwell
                svc = FLOOR_REQUEST[floor_q] ? floor_oh : '0;
                if (timer_q == '0) begin
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q - TIMER_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Servicing a floor overrides a same-cycle request for it
        pending_d = (pending_q | FLOOR_REQUEST) & ~svc;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            pending_q <= '0;
            timer_q   <= '0;
            clear_q   <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            clear_q   <= svc;
        end
    end

    assign CURRENT_FLOOR      = floor_q;
    assign HALTED             = state_q != MOVE;
    assign DOOR_OPEN          = state_q == DOOR;
    assign MOVING_UP          = (state_q == MOVE) && dir_q;
    assign MOVING_DOWN        = (state_q == MOVE) && !dir_q;
    assign PENDING            = pending_q;
    assign CLEAR_FLOOR_BUTTON = clear_q;
endmodule
